// File: rtl/output_buffer_ctrl.sv
// output_buffer_ctrl
//
// Sequences the output_buffer of an ARRAY_N x ARRAY_N systolic array.
// Each K-tile's skewed result stream is captured for LOAD_BEATS cycles and
// then folded into the accumulator. After the last K-tile, ARRAY_N
// accumulated rows are drained under downstream backpressure, and then the
// accumulator is cleared.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle job request, sampled only in IDLE
//   k_tiles       K-tiles per job, latched on start (0 is treated as 1)
//   res_valid     first result beat of a tile is present this cycle
//   out_ready     downstream accepts a drained row this cycle
//   abort         synchronous abort of the running job
//   load_en       capture the current result beat
//   load_clear    clear the load stage
//   acc_enable    fold the load stage into the accumulator
//   acc_clear     clear the accumulator
//   out_en        a row transfers this cycle
//   out_row       index of the row transferred while out_en is high
//   tile_idx      current K-tile, 0-based
//   busy          high whenever the controller is not IDLE
//   done          one-cycle pulse on normal completion
//   err_overrun   sticky: a new tile arrived while one was still loading

module output_buffer_ctrl #(
  parameter  int ARRAY_N    = 4,
  parameter  int LOAD_BEATS = 17,
  parameter  int KT_W       = 8,
  localparam int ROW_W      = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1,
  localparam int BEAT_W     = $clog2(LOAD_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KT_W-1:0]  k_tiles,
  input  logic             res_valid,
  input  logic             out_ready,
  input  logic             abort,
  output logic             load_en,
  output logic             load_clear,
  output logic             acc_enable,
  output logic             acc_clear,
  output logic             out_en,
  output logic [ROW_W-1:0] out_row,
  output logic [KT_W-1:0]  tile_idx,
  output logic             busy,
  output logic             done,
  output logic             err_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RES,
    LOAD,
    ACC,
    OUT,
    CLEAR,
    ABORT
  } state_t;

  state_t state;
  state_t next_state;

  logic [BEAT_W-1:0] beat_cnt;
  logic [KT_W-1:0]   k_lat;
  logic              last_tile;
  logic              last_row;
  logic              last_beat;

  assign last_tile = (tile_idx == (k_lat - KT_W'(1)));
  assign last_row  = (out_row == ROW_W'(ARRAY_N - 1));
  assign last_beat = (beat_cnt == BEAT_W'(LOAD_BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort is checked first in every active state so it overrides
  // res_valid, out_ready and completion. The only input-to-output
  // paths are res_valid->load_en in WAIT_RES and out_ready->out_en in OUT.
  always_comb begin
    next_state = state;
    load_en    = 1'b0;
    load_clear = 1'b0;
    acc_enable = 1'b0;
    acc_clear  = 1'b0;
    out_en     = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          next_state = WAIT_RES;
        end
      end
      WAIT_RES: begin
        load_en = res_valid;
        if (abort) begin
          next_state = ABORT;
        end else if (res_valid) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        load_en = 1'b1;
        if (abort) begin
          next_state = ABORT;
        end else if (last_beat) begin
          next_state = ACC;
        end
      end
      ACC: begin
        acc_enable = 1'b1;
        load_clear = 1'b1;
        if (abort) begin
          next_state = ABORT;
        end else if (last_tile) begin
          next_state = OUT;
        end else begin
          next_state = WAIT_RES;
        end
      end
      OUT: begin
        out_en = out_ready;
        if (abort) begin
          next_state = ABORT;
        end else if (out_ready && last_row) begin
          next_state = CLEAR;
        end
      end
      CLEAR: begin
        acc_clear = 1'b1;
        done      = 1'b1;
        if (abort) begin
          next_state = ABORT;
        end else begin
          next_state = IDLE;
        end
      end
      ABORT: begin
        load_clear = 1'b1;
        acc_clear  = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Counters and sticky error flag. Counter updates are suppressed on an
  // abort cycle; the next accepted start reinitialises everything anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt    <= '0;
      k_lat       <= '0;
      tile_idx    <= '0;
      out_row     <= '0;
      err_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_lat       <= (k_tiles == '0) ? KT_W'(1) : k_tiles;
            tile_idx    <= '0;
            beat_cnt    <= '0;
            out_row     <= '0;
            err_overrun <= 1'b0;
          end
        end
        WAIT_RES: begin
          if (!abort && res_valid) begin
            beat_cnt <= BEAT_W'(1);
          end
        end
        LOAD: begin
          if (!abort) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (res_valid) begin
              err_overrun <= 1'b1;
            end
          end
        end
        ACC: begin
          if (!abort) begin
            if (res_valid) begin
              err_overrun <= 1'b1;
            end
            if (last_tile) begin
              out_row <= '0;
            end else begin
              tile_idx <= tile_idx + KT_W'(1);
            end
          end
        end
        OUT: begin
          if (!abort && out_ready) begin
            out_row <= last_row ? '0 : out_row + ROW_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// tb_output_buffer_ctrl
//
// Self-checking bench for output_buffer_ctrl: a table of per-cycle
// {inputs, expected outputs} vectors covering a single-tile job, IDLE
// corner cases and drain backpressure, followed by hand-written sequences
// for multi-tile jobs, abort, overrun and asynchronous reset.

`timescale 1ns/1ps

module tb_output_buffer_ctrl;

  localparam int ARRAY_N    = 4;
  localparam int LOAD_BEATS = 17;
  localparam int KT_W       = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] k_tiles;
  logic       res_valid;
  logic       out_ready;
  logic       abort;
  logic       load_en;
  logic       load_clear;
  logic       acc_enable;
  logic       acc_clear;
  logic       out_en;
  logic [1:0] out_row;
  logic [7:0] tile_idx;
  logic       busy;
  logic       done;
  logic       err_overrun;

  logic [17:0] outs;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        st;
    logic [7:0]  k;
    logic        rv;
    logic        rdy;
    logic        ab;
    logic [17:0] exp_outs;
  } vec_t;

  vec_t vecs[$];

  output_buffer_ctrl #(
    .ARRAY_N   (ARRAY_N),
    .LOAD_BEATS(LOAD_BEATS),
    .KT_W      (KT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_tiles    (k_tiles),
    .res_valid  (res_valid),
    .out_ready  (out_ready),
    .abort      (abort),
    .load_en    (load_en),
    .load_clear (load_clear),
    .acc_enable (acc_enable),
    .acc_clear  (acc_clear),
    .out_en     (out_en),
    .out_row    (out_row),
    .tile_idx   (tile_idx),
    .busy       (busy),
    .done       (done),
    .err_overrun(err_overrun)
  );

  assign outs = {load_en, load_clear, acc_enable, acc_clear, out_en,
                 out_row, tile_idx, busy, done, err_overrun};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [17:0] mk(input logic le, input logic lc,
                                     input logic ae, input logic ac,
                                     input logic oe, input logic [1:0] row,
                                     input logic [7:0] ti, input logic bz,
                                     input logic dn, input logic er);
    return {le, lc, ae, ac, oe, row, ti, bz, dn, er};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp_val);
    checks++;
    if (act === exp_val) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t",
               name, act, exp_val, $time);
    end
  endtask

  task automatic addVec(input logic st, input logic [7:0] k, input logic rv,
                        input logic rdy, input logic ab,
                        input logic [17:0] e);
    vec_t v;
    v.st       = st;
    v.k        = k;
    v.rv       = rv;
    v.rdy      = rdy;
    v.ab       = ab;
    v.exp_outs = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    start     = v.st;
    k_tiles   = v.k;
    res_valid = v.rv;
    out_ready = v.rdy;
    abort     = v.ab;
  endtask

  // Issues start with k, then waits for the first acc_enable, driving
  // res_valid on the second cycle after start. Returns at posedge+1 of the
  // cycle following that ACC.
  task automatic startAndWaitAcc(input logic [7:0] k, input logic rdy,
                                 output bit got);
    @(posedge clk);
    #1;
    start     = 1'b1;
    k_tiles   = k;
    res_valid = 1'b0;
    out_ready = rdy;
    abort     = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    got   = 1'b0;
    for (int c = 1; c < 100 && !got; c++) begin
      res_valid = (c == 2);
      @(negedge clk);
      got = acc_enable;
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0;
  endtask

  task automatic runJob(input logic [7:0] k, input int tiles,
                        input int ovr_at);
    int  run    = 0;
    int  bursts = 0;
    int  accs   = 0;
    int  oes    = 0;
    int  acs    = 0;
    bit  seen_done = 1'b0;
    bit  fire      = 1'b0;
    @(posedge clk);
    #1;
    start     = 1'b1;
    k_tiles   = k;
    res_valid = 1'b0;
    out_ready = 1'b1;
    abort     = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 400 && !seen_done; cyc++) begin
      res_valid = (cyc == 2) || fire || (ovr_at > 0 && cyc == ovr_at);
      @(negedge clk);
      fire = 1'b0;
      if (cyc == 1) checkOutput("err_clear_on_start", err_overrun, 0);
      if (load_en) begin
        run++;
      end else if (run > 0) begin
        checkOutput("burst_len", run, LOAD_BEATS);
        bursts++;
        run = 0;
      end
      if (acc_enable) begin
        checkOutput("acc_tile_idx", tile_idx, accs);
        accs++;
        fire = (accs < tiles);
      end
      if (out_en) oes++;
      if (acc_clear) acs++;
      if (ovr_at > 0 && cyc == ovr_at + 1) begin
        checkOutput("err_set_after_overlap", err_overrun, 1);
      end
      if (done) begin
        seen_done = 1'b1;
        checkOutput("err_at_done", err_overrun, (ovr_at > 0));
      end
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0;
    if (!seen_done) checkOutput("job_timeout", 0, 1);
    @(negedge clk);
    checkOutput("busy_low_after_job", busy, 0);
    checkOutput("burst_count", bursts, tiles);
    checkOutput("acc_count", accs, tiles);
    checkOutput("drain_rows", oes, ARRAY_N);
    checkOutput("acc_clear_count", acs, 1);
  endtask

  initial begin
    logic [17:0] zero;
    logic [17:0] bz;
    logic [17:0] ld;
    logic [1:0]  rows[7];
    logic        pat[7];
    bit          got;

    zero = '0;
    bz   = mk(0, 0, 0, 0, 0, 2'd0, 8'd0, 1, 0, 0);
    ld   = mk(1, 0, 0, 0, 0, 2'd0, 8'd0, 1, 0, 0);

    // Single-tile job: start at cycle 0, res_valid at cycle 3, start
    // repeated during CLEAR must be ignored.
    addVec(1, 8'd1, 0, 1, 0, zero);
    addVec(0, 8'd0, 0, 1, 0, bz);
    addVec(0, 8'd0, 0, 1, 0, bz);
    addVec(0, 8'd0, 1, 1, 0, ld);
    for (int c = 4; c <= 19; c++) addVec(0, 8'd0, 0, 1, 0, ld);
    addVec(0, 8'd0, 0, 1, 0, mk(0, 1, 1, 0, 0, 2'd0, 8'd0, 1, 0, 0));
    for (int r = 0; r < 4; r++) begin
      addVec(0, 8'd0, 0, 1, 0, mk(0, 0, 0, 0, 1, 2'(r), 8'd0, 1, 0, 0));
    end
    addVec(1, 8'd1, 0, 1, 0, mk(0, 0, 0, 1, 0, 2'd0, 8'd0, 1, 1, 0));
    addVec(0, 8'd0, 0, 1, 0, zero);

    // Abort and res_valid in IDLE are ignored.
    addVec(0, 8'd0, 1, 0, 1, zero);
    addVec(0, 8'd0, 0, 0, 0, zero);

    // Drain backpressure with out_ready pattern 1,0,0,1,1,0,1.
    pat  = '{1, 0, 0, 1, 1, 0, 1};
    rows = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    addVec(1, 8'd1, 0, 0, 0, zero);
    addVec(0, 8'd0, 1, 0, 0, ld);
    for (int c = 2; c <= 17; c++) addVec(0, 8'd0, 0, 0, 0, ld);
    addVec(0, 8'd0, 0, 0, 0, mk(0, 1, 1, 0, 0, 2'd0, 8'd0, 1, 0, 0));
    for (int i = 0; i < 7; i++) begin
      addVec(0, 8'd0, 0, pat[i], 0,
             mk(0, 0, 0, 0, pat[i], rows[i], 8'd0, 1, 0, 0));
    end
    addVec(0, 8'd0, 0, 0, 0, mk(0, 0, 0, 1, 0, 2'd0, 8'd0, 1, 1, 0));
    addVec(0, 8'd0, 0, 0, 0, zero);

    rst       = 1'b1;
    start     = 1'b0;
    k_tiles   = '0;
    res_valid = 1'b0;
    out_ready = 1'b0;
    abort     = 1'b0;
    $display("[TB] reset phase");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", outs, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", outs, 0);

    $display("[TB] table vectors: %0d", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), outs, vecs[i].exp_outs);
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    res_valid = 1'b0;
    out_ready = 1'b0;

    $display("[TB] three-tile job");
    runJob(8'd3, 3, 0);

    $display("[TB] abort during LOAD of tile 1");
    startAndWaitAcc(8'd2, 1'b1, got);
    if (!got) checkOutput("abort_reach_acc", 0, 1);
    res_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(negedge clk);
    checkOutput("abort_in_load", {load_en, tile_idx}, {1'b1, 8'd1});
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_pulse", outs, mk(0, 1, 0, 1, 0, 2'd0, 8'd1, 1, 0, 0));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("idle_after_abort", outs, mk(0, 0, 0, 0, 0, 2'd0, 8'd1, 0, 0, 0));

    $display("[TB] clean job after abort with k_tiles=0");
    runJob(8'd0, 1, 0);

    $display("[TB] overrun during LOAD");
    runJob(8'd1, 1, 8);
    runJob(8'd1, 1, 0);

    $display("[TB] asynchronous reset mid-OUT");
    startAndWaitAcc(8'd1, 1'b0, got);
    if (!got) checkOutput("reset_reach_acc", 0, 1);
    @(negedge clk);
    checkOutput("stall_out", {busy, out_en, out_row}, 4'b1000);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    checkOutput("out_en_follows_ready", out_en, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs", outs, 0);
    @(negedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_async_reset", outs, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
